// File: rtl/spi_byte_master.sv
// Byte-level SPI mode-0 master: shifts one byte out MSB-first on MOSI while
// capturing MISO, then pulses done with the received byte. Chip select is the client's.
`timescale 1ns/1ps

module spi_byte_master #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       spi_start_i,
  input  logic [7:0] spi_out_i,
  output logic [7:0] spi_in_o,
  output logic       spi_done_o,
  output logic       spi_busy_o,
  output logic       spi_sck_o,
  output logic       spi_mosi_o,
  input  logic       spi_miso_i
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOW,
    S_HIGH,
    S_DONE
  } state_t;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  state_t     r_state;
  logic [7:0] r_tx_sr;
  logic [7:0] r_rx_sr;
  logic [2:0] r_bit_cnt;
  logic [7:0] r_div_cnt;
  logic [7:0] r_in;
  logic       r_done;
  logic       r_busy;
  logic       r_sck;
  logic       r_mosi;

  logic       w_div_wrap;
  logic [7:0] w_rx_next;

  assign w_div_wrap = (r_div_cnt == DIV_LAST);
  assign w_rx_next  = {r_rx_sr[6:0], spi_miso_i};

  // Outputs are registered alongside the state so that each one changes on the
  // same edge as the state it belongs to; nothing reaches a pin from spi_start_i.
  always_ff @(posedge clk_i) begin
    // NOTE: reset is synchronous here, so it lives inside the clocked block and
    // is only seen at a rising edge; every register in this block clears with it.
    if (!reset_i) begin
      r_state   <= S_IDLE;
      r_tx_sr   <= 8'h00;
      r_rx_sr   <= 8'h00;
      r_bit_cnt <= 3'd0;
      r_div_cnt <= 8'h00;
      r_in      <= 8'h00;
      r_done    <= 1'b0;
      r_busy    <= 1'b0;
      r_sck     <= 1'b0;
      r_mosi    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every decision below reads
      // the register values from before this edge regardless of statement order.
      case (r_state)
        S_IDLE: begin
          r_sck  <= 1'b0;
          r_mosi <= 1'b0;
          r_busy <= 1'b0;
          r_done <= 1'b0;
          if (spi_start_i) begin
            r_tx_sr   <= spi_out_i;
            r_bit_cnt <= 3'd0;
            r_div_cnt <= 8'h00;
            r_mosi    <= spi_out_i[7];
            r_busy    <= 1'b1;
            r_state   <= S_LOW;
          end
        end

        S_LOW: begin
          if (w_div_wrap) begin
            r_div_cnt <= 8'h00;
            r_sck     <= 1'b1;
            r_state   <= S_HIGH;
          end else begin
            r_div_cnt <= r_div_cnt + 8'd1;
          end
        end

        S_HIGH: begin
          if (w_div_wrap) begin
            // Last clk edge before SCK falls: the slave's bit has had a full
            // high phase to settle.
            r_rx_sr <= w_rx_next;
            r_sck   <= 1'b0;
            if (r_bit_cnt == 3'd7) begin
              r_in    <= w_rx_next;
              r_mosi  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_tx_sr   <= {r_tx_sr[6:0], 1'b0};
              r_mosi    <= r_tx_sr[6];
              r_bit_cnt <= r_bit_cnt + 3'd1;
              r_div_cnt <= 8'h00;
              r_state   <= S_LOW;
            end
          end else begin
            r_div_cnt <= r_div_cnt + 8'd1;
          end
        end

        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign spi_in_o   = r_in;
  assign spi_done_o = r_done;
  assign spi_busy_o = r_busy;
  assign spi_sck_o  = r_sck;
  assign spi_mosi_o = r_mosi;

endmodule

// File: tb/tb_spi_byte_master.sv
// Bench for spi_byte_master: two instances (CLK_DIV=2 and CLK_DIV=1) behind a
// selector, a mode-0 slave / loopback on MISO, and a transfer-level reference.
`timescale 1ns/1ps

module tb_spi_byte_master;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] out = 8'h00;
  logic       dut_sel = 1'b0;   // 0: CLK_DIV=2 instance, 1: CLK_DIV=1 instance
  logic       loopback = 1'b0;
  logic [7:0] s_byte = 8'h00;
  logic       miso;

  logic       start1, start2;
  logic [7:0] in1, in2;
  logic       done1, done2, busy1, busy2, sck1, sck2, mosi1, mosi2;
  logic [7:0] w_in;
  logic       w_done, w_busy, w_sck, w_mosi;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int fall_cnt = 0;
  int fall_base = 0;
  int s_idx;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign start1 = start & dut_sel;
  assign start2 = start & ~dut_sel;
  assign w_in   = dut_sel ? in1   : in2;
  assign w_done = dut_sel ? done1 : done2;
  assign w_busy = dut_sel ? busy1 : busy2;
  assign w_sck  = dut_sel ? sck1  : sck2;
  assign w_mosi = dut_sel ? mosi1 : mosi2;

  // Mode-0 slave: presents its MSB up front and moves to the next bit on each SCK fall.
  always @(negedge w_sck) fall_cnt <= fall_cnt + 1;
  assign s_idx = fall_cnt - fall_base;

  always_comb begin
    miso = 1'b0;
    if (loopback) miso = w_mosi;
    else if (s_idx >= 0 && s_idx < 8) miso = s_byte[3'(7 - s_idx)];
  end

  spi_byte_master #(.CLK_DIV(2)) u_dut2 (
    .clk_i(clk), .reset_i(reset_n), .spi_start_i(start2), .spi_out_i(out),
    .spi_in_o(in2), .spi_done_o(done2), .spi_busy_o(busy2), .spi_sck_o(sck2),
    .spi_mosi_o(mosi2), .spi_miso_i(miso)
  );

  spi_byte_master #(.CLK_DIV(1)) u_dut1 (
    .clk_i(clk), .reset_i(reset_n), .spi_start_i(start1), .spi_out_i(out),
    .spi_in_o(in1), .spi_done_o(done1), .spi_busy_o(busy1), .spi_sck_o(sck1),
    .spi_mosi_o(mosi1), .spi_miso_i(miso)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: a loopback returns the transmitted byte, a slave returns its own byte.
  function automatic logic [7:0] model_rx(input logic [7:0] tx, input bit lp, input logic [7:0] sb);
    return lp ? tx : sb;
  endfunction

  // One transfer on the selected instance; returns on the sampled DONE cycle.
  task automatic run_byte(input logic [7:0] tx, input bit lp, input logic [7:0] sb,
                          input logic [7:0] exp_rx, input string tag, output int done_at);
    int cd, n, rises, busy_cnt;
    bit got, prev;
    logic [7:0] mosi_bits, rx;
    logic sck_d, mosi_d;
    cd = dut_sel ? 1 : 2;
    n = 0; rises = 0; busy_cnt = 0; got = 0; prev = 1'b0;
    mosi_bits = 8'h00; rx = 8'h00; sck_d = 1'b1; mosi_d = 1'b1; done_at = -1;
    @(negedge clk);
    check({tag, "_sck_idle"}, 32'(w_sck), 32'd0);
    out = tx; s_byte = sb; loopback = lp; fall_base = fall_cnt; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (!got && n < 200) begin
      if (w_busy) busy_cnt++;
      if (w_sck && !prev) begin
        rises++;
        mosi_bits = {mosi_bits[6:0], w_mosi};
      end
      prev = w_sck;
      if (w_done) begin
        got = 1'b1; done_at = cyc; rx = w_in; sck_d = w_sck; mosi_d = w_mosi;
      end else begin
        @(negedge clk);
        n++;
      end
    end
    if (!got) begin
      check({tag, "_timeout"}, 32'd0, 32'd1);
    end else begin
      check({tag, "_latency"}, 32'(n), 32'(16 * cd));
      check({tag, "_rises"}, 32'(rises), 32'd8);
      check({tag, "_mosi"}, 32'(mosi_bits), 32'(tx));
      check({tag, "_rx"}, 32'(rx), 32'(exp_rx));
      check({tag, "_busy_len"}, 32'(busy_cnt), 32'(16 * cd + 1));
      check({tag, "_sck_done"}, 32'(sck_d), 32'd0);
      check({tag, "_mosi_done"}, 32'(mosi_d), 32'd0);
    end
  endtask

  typedef struct {
    logic [7:0] tx;
    bit         lp;
    logic [7:0] sb;
    bit         sel;
    logic [7:0] exp_rx;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int d0, d1, d2, n, dn, cnt;
    logic [7:0] tx, sb, mbits;
    bit lp, prev, got;

    vecs[0] = '{tx: 8'hA5, lp: 1'b1, sb: 8'h00, sel: 1'b0, exp_rx: 8'hA5};
    vecs[1] = '{tx: 8'h03, lp: 1'b0, sb: 8'h3C, sel: 1'b0, exp_rx: 8'h3C};
    vecs[2] = '{tx: 8'h5A, lp: 1'b0, sb: 8'h80, sel: 1'b0, exp_rx: 8'h80};
    vecs[3] = '{tx: 8'hFF, lp: 1'b0, sb: 8'h01, sel: 1'b1, exp_rx: 8'h01};
    vecs[4] = '{tx: 8'h00, lp: 1'b1, sb: 8'hFF, sel: 1'b1, exp_rx: 8'h00};
    vecs[5] = '{tx: 8'hC3, lp: 1'b0, sb: 8'h96, sel: 1'b1, exp_rx: 8'h96};

    // Reset state of both instances.
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("rst_in", 32'({in1, in2}), 32'd0);
    check("rst_ctl", 32'({done1, busy1, sck1, mosi1, done2, busy2, sck2, mosi2}), 32'd0);

    // Table vectors; after each one done must drop and spi_in_o must hold.
    for (int i = 0; i < 6; i++) begin
      dut_sel = vecs[i].sel;
      run_byte(vecs[i].tx, vecs[i].lp, vecs[i].sb, vecs[i].exp_rx, $sformatf("vec%0d", i), d0);
      @(negedge clk);
      check($sformatf("vec%0d_done_width", i), 32'(w_done), 32'd0);
      check($sformatf("vec%0d_in_hold", i), 32'(w_in), 32'(vecs[i].exp_rx));
    end

    // CLK_DIV=1 back-to-back: start on the cycle after each done.
    dut_sel = 1'b1;
    run_byte(8'h03, 1'b1, 8'h00, 8'h03, "b2b0", d0);
    run_byte(8'h00, 1'b1, 8'h00, 8'h00, "b2b1", d1);
    run_byte(8'h00, 1'b1, 8'h00, 8'h00, "b2b2", d2);
    check("b2b_gap01", 32'(d1 - d0), 32'd18);
    check("b2b_gap12", 32'(d2 - d1), 32'd18);

    // Start held high through a byte, spi_out_i changed mid-byte (CLK_DIV=2, loopback).
    dut_sel = 1'b0;
    @(negedge clk);
    out = 8'h96; loopback = 1'b1; start = 1'b1;
    @(negedge clk);
    n = 0; got = 1'b0; prev = 1'b0; mbits = 8'h00;
    while (!got && n < 200) begin
      if (n == 5) out = 8'h69;
      if (w_sck && !prev) mbits = {mbits[6:0], w_mosi};
      prev = w_sck;
      if (w_done) got = 1'b1;
      else begin @(negedge clk); n++; end
    end
    check("hold_done_seen", 32'(got), 32'd1);
    check("hold_mosi", 32'(mbits), 32'h96);
    check("hold_rx", 32'(w_in), 32'h96);
    @(negedge clk);
    check("hold_idle_busy", 32'({w_busy, w_done}), 32'd0);
    check("hold_idle_in", 32'(w_in), 32'h96);
    @(negedge clk);
    check("hold_restart_busy", 32'(w_busy), 32'd1);
    start = 1'b0;
    n = 0; got = 1'b0;
    while (!got && n < 200) begin
      if (w_done) got = 1'b1;
      else begin @(negedge clk); n++; end
    end
    check("hold2_latency", 32'(n), 32'd32);
    check("hold2_rx", 32'(w_in), 32'h69);

    // Reset during bit 4: everything clears, no done for the aborted byte.
    @(negedge clk);
    out = 8'h3C; loopback = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0; cnt = 0; prev = 1'b0;
    while (cnt < 5 && n < 200) begin
      if (w_sck && !prev) cnt++;
      prev = w_sck;
      if (cnt < 5) begin @(negedge clk); n++; end
    end
    check("rst_mid_reached_bit4", 32'(cnt), 32'd5);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    check("rst_mid_ctl", 32'({w_sck, w_busy, w_done, w_mosi}), 32'd0);
    check("rst_mid_in", 32'(w_in), 32'h00);
    dn = 0;
    repeat (40) begin
      @(negedge clk);
      if (w_done) dn++;
    end
    check("rst_mid_no_done", 32'(dn), 32'd0);
    run_byte(8'hFF, 1'b1, 8'h00, 8'hFF, "post_rst", d0);

    // Randomized transfers against the transfer-level reference.
    for (int i = 0; i < 16; i++) begin
      dut_sel = 1'($urandom_range(0, 1));
      tx = 8'($urandom);
      sb = 8'($urandom);
      lp = 1'($urandom_range(0, 1));
      run_byte(tx, lp, sb, model_rx(tx, lp, sb), $sformatf("rnd%0d", i), d0);
    end

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
